// File: rtl/branch_controller_pkg.sv
// Shared CPU definitions used by the branch controller and its comparator:
// compare-select encodings, controller state encoding and instruction length.
package branch_controller_pkg;

  // Compare-select encodings understood by comparator_unit.
  // Codes 3'b010 and 3'b011 are unassigned and compare false.
  localparam logic [2:0] CMP_OP_EQ  = 3'b000;
  localparam logic [2:0] CMP_OP_NE  = 3'b001;
  localparam logic [2:0] CMP_OP_LT  = 3'b100;
  localparam logic [2:0] CMP_OP_GE  = 3'b101;
  localparam logic [2:0] CMP_OP_LTU = 3'b110;
  localparam logic [2:0] CMP_OP_GEU = 3'b111;

  // Length in bytes of one instruction; the link address is Pc + INSN_LEN.
  localparam int INSN_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EVAL     = 3'd1,
    ST_DONE     = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_ERROR    = 3'd4
  } state_e;

endpackage

// File: rtl/branch_controller_comparator.sv
// comparator_unit: shared branch comparator. Pure combinational compare of
// two operands under a CMP_OP_* select; unknown selects compare false.
module comparator_unit
  import branch_controller_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] lhs,
  input  logic [XLEN-1:0] rhs,
  input  logic [2:0]      op,
  output logic            result
);

  // Evaluate the selected relation between the two operands.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    result = 1'b0;
    case (op)
      CMP_OP_EQ:  result = (lhs == rhs);
      CMP_OP_NE:  result = (lhs != rhs);
      CMP_OP_LT:  result = ($signed(lhs) <  $signed(rhs));
      CMP_OP_GE:  result = ($signed(lhs) >= $signed(rhs));
      CMP_OP_LTU: result = (lhs <  rhs);
      CMP_OP_GEU: result = (lhs >= rhs);
      default:    result = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_controller.sv
// branch_controller: accepts one branch/jump from decode, evaluates it with
// the shared comparator_unit, then either redirects fetch, reports a
// resolution, or flags a misaligned taken target.
// Optional feature: define BRANCH_PREDICT_EN to redirect only on a
// misprediction of i_Predicted_Taken.
module branch_controller
  import branch_controller_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int RESET_PC_ALIGN = 2
) (
  input  logic            i_Clock,
  input  logic            i_Reset_N,
  input  logic            i_Branch_Valid,
  output logic            o_Branch_Ready,
  input  logic [XLEN-1:0] i_Rs1,
  input  logic [XLEN-1:0] i_Rs2,
  input  logic [XLEN-1:0] i_Pc,
  input  logic [XLEN-1:0] i_Imm,
  input  logic [2:0]      i_Compare_Select,
  input  logic            i_Is_Jal,
  input  logic            i_Is_Jalr,
  input  logic            i_Predicted_Taken,
  input  logic            i_Flush,
  output logic            o_Redirect_Valid,
  input  logic            i_Redirect_Ready,
  output logic [XLEN-1:0] o_Redirect_Target,
  output logic            o_Done,
  output logic            o_Taken,
  output logic [XLEN-1:0] o_Link_Value,
  output logic            o_Misaligned
);

  // Low target bits that must be zero for a taken target.
  localparam logic [XLEN-1:0] ALIGN_MASK =
    XLEN'((64'(1) << RESET_PC_ALIGN) - 64'(1));

  state_e state, state_next;

  // Operands captured at acceptance.
  logic [XLEN-1:0] rs1_q, rs2_q, pc_q, imm_q;
  logic [2:0]      sel_q;
  logic            jal_q, jalr_q;

  // Resolution captured in EVAL; these drive the outputs directly.
  logic            taken_q;
  logic [XLEN-1:0] target_q, link_q;

  // Combinational evaluation of the captured instruction.
  logic            cmp_result;
  logic            accept;
  logic            taken_eval, misaligned_eval, redirect_eval;
  logic [XLEN-1:0] jump_target, link_eval, target_eval;

  assign accept = (state == ST_IDLE) && !i_Flush && i_Branch_Valid;

  comparator_unit #(.XLEN(XLEN)) u_cmp (
    .lhs    (rs1_q),
    .rhs    (rs2_q),
    .op     (sel_q),
    .result (cmp_result)
  );

`ifdef BRANCH_PREDICT_EN
  logic pred_q;
`else
  logic unused_pred;
  assign unused_pred = i_Predicted_Taken;
`endif

  // Capture operands on acceptance; no reset needed since EVAL only reads them after a capture.
  always_ff @(posedge i_Clock) begin
    // NOTE: plain data registers are left unreset; only state that steers control or drives outputs is reset.
    if (accept) begin
      rs1_q  <= i_Rs1;
      rs2_q  <= i_Rs2;
      pc_q   <= i_Pc;
      imm_q  <= i_Imm;
      sel_q  <= i_Compare_Select;
      jal_q  <= i_Is_Jal;
      jalr_q <= i_Is_Jalr;
`ifdef BRANCH_PREDICT_EN
      pred_q <= i_Predicted_Taken;
`endif
    end
  end

  // Resolve direction, target, link and the redirect decision from captured operands.
  always_comb begin
    taken_eval = jal_q || jalr_q || cmp_result;
    link_eval  = pc_q + XLEN'(INSN_LEN);
    if (jalr_q) begin
      jump_target = rs1_q + imm_q;
      jump_target = {jump_target[XLEN-1:1], 1'b0};
    end else begin
      jump_target = pc_q + imm_q;
    end
    misaligned_eval = taken_eval && ((jump_target & ALIGN_MASK) != '0);
`ifdef BRANCH_PREDICT_EN
    redirect_eval = (taken_eval != pred_q);
    target_eval   = taken_eval ? jump_target : link_eval;
`else
    redirect_eval = taken_eval;
    target_eval   = jump_target;
`endif
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!i_Reset_N) state <= ST_IDLE;
    else            state <= state_next;
  end

  // Next-state selection; flush overrides everything and returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (accept) state_next = ST_EVAL;
      ST_EVAL:     state_next = misaligned_eval ? ST_ERROR :
                                redirect_eval   ? ST_REDIRECT : ST_DONE;
      ST_DONE:     state_next = ST_IDLE;
      ST_REDIRECT: if (i_Redirect_Ready) state_next = ST_IDLE;
      ST_ERROR:    state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
    if (i_Flush) state_next = ST_IDLE;
  end

  // Register the resolution at the end of EVAL so outputs come from flops.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) begin
      taken_q  <= 1'b0;
      target_q <= '0;
      link_q   <= '0;
    end else if (state == ST_EVAL) begin
      taken_q  <= taken_eval;
      target_q <= target_eval;
      link_q   <= link_eval;
    end
  end

  // Decode handshake and pulse outputs from the current state; flush masks them.
  always_comb begin
    o_Branch_Ready   = (state == ST_IDLE) && !i_Flush;
    o_Redirect_Valid = (state == ST_REDIRECT) && !i_Flush;
    o_Done           = !i_Flush && ((state == ST_DONE) ||
                       ((state == ST_REDIRECT) && i_Redirect_Ready));
    o_Misaligned     = (state == ST_ERROR) && !i_Flush;
  end

  assign o_Taken           = taken_q;
  assign o_Redirect_Target = target_q;
  assign o_Link_Value      = link_q;

endmodule

// File: tb/tb_branch_controller.sv
// Self-checking bench for branch_controller: directed scenarios plus
// randomized instructions compared against a behavioural model.
// Honours BRANCH_PREDICT_EN the same way the design does.
module tb_branch_controller;
  import branch_controller_pkg::*;

  typedef struct {
    logic [31:0] rs1, rs2, pc, imm;
    logic [2:0]  sel;
    logic        jal, jalr, pred;
  } instr_t;

  typedef enum int {K_DONE, K_REDIRECT, K_ERROR} kind_e;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_valid = 1'b0;
  logic        branch_ready;
  logic [31:0] rs1 = '0, rs2 = '0, pc = '0, imm = '0;
  logic [2:0]  cmp_sel = '0;
  logic        is_jal = 1'b0, is_jalr = 1'b0, pred_taken = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid;
  logic        redirect_ready = 1'b0;
  logic [31:0] redirect_target;
  logic        done, taken, misaligned;
  logic [31:0] link_value;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_controller #(.XLEN(32), .RESET_PC_ALIGN(2)) dut (
    .i_Clock           (clk),
    .i_Reset_N         (rst_n),
    .i_Branch_Valid    (branch_valid),
    .o_Branch_Ready    (branch_ready),
    .i_Rs1             (rs1),
    .i_Rs2             (rs2),
    .i_Pc              (pc),
    .i_Imm             (imm),
    .i_Compare_Select  (cmp_sel),
    .i_Is_Jal          (is_jal),
    .i_Is_Jalr         (is_jalr),
    .i_Predicted_Taken (pred_taken),
    .i_Flush           (flush),
    .o_Redirect_Valid  (redirect_valid),
    .i_Redirect_Ready  (redirect_ready),
    .o_Redirect_Target (redirect_target),
    .o_Done            (done),
    .o_Taken           (taken),
    .o_Link_Value      (link_value),
    .o_Misaligned      (misaligned)
  );

  // Reference model: RISC-V branch semantics in plain arithmetic.
  function automatic void model(input instr_t x, output kind_e kind, output logic tk,
                                output logic [31:0] tgt, output logic [31:0] lnk);
    logic [31:0] dest;
    logic        redir;
    if (x.jal || x.jalr) tk = 1'b1;
    else begin
      case (x.sel)
        CMP_OP_EQ:  tk = (x.rs1 == x.rs2);
        CMP_OP_NE:  tk = (x.rs1 != x.rs2);
        CMP_OP_LT:  tk = (int'(x.rs1) <  int'(x.rs2));
        CMP_OP_GE:  tk = (int'(x.rs1) >= int'(x.rs2));
        CMP_OP_LTU: tk = (longint'({32'd0, x.rs1}) <  longint'({32'd0, x.rs2}));
        CMP_OP_GEU: tk = (longint'({32'd0, x.rs1}) >= longint'({32'd0, x.rs2}));
        default:    tk = 1'b0;
      endcase
    end
    lnk = x.pc + 32'd4;
    if (x.jalr) dest = ((x.rs1 + x.imm) / 2) * 2;
    else        dest = x.pc + x.imm;
`ifdef BRANCH_PREDICT_EN
    redir = (tk != x.pred);
    tgt   = tk ? dest : lnk;
`else
    redir = tk;
    tgt   = dest;
`endif
    if (tk && (dest % 4 != 0)) kind = K_ERROR;
    else if (redir)            kind = K_REDIRECT;
    else                       kind = K_DONE;
  endfunction

  function automatic instr_t mk(input logic [2:0] s, input logic j, input logic jr,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] p, input logic [31:0] i,
                                input logic pr);
    instr_t x;
    x.sel = s; x.jal = j; x.jalr = jr; x.rs1 = a; x.rs2 = b;
    x.pc = p; x.imm = i; x.pred = pr;
    return x;
  endfunction

  task automatic present(input instr_t x);
    rs1 = x.rs1; rs2 = x.rs2; pc = x.pc; imm = x.imm; cmp_sel = x.sel;
    is_jal = x.jal; is_jalr = x.jalr; pred_taken = x.pred;
    branch_valid = 1'b1;
  endtask

  // Drive one instruction end to end and check every cycle of its occupancy.
  task automatic run_instr(input string tag, input instr_t x, input int delay);
    kind_e       kind;
    logic        etk;
    logic [31:0] etgt, elnk;
    model(x, kind, etk, etgt, elnk);
    @(negedge clk);
    present(x);
    #1;
    checks++;
    if (branch_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_ready: got %b want 1", tag, branch_ready);
    end
    @(negedge clk);                     // accepted on the edge just passed: EVAL
    branch_valid = 1'b0;
    #1;
    checks++;
    if ({branch_ready, done, redirect_valid, misaligned} !== 4'b0000) begin
      errors++; $display("FAIL %s eval_quiet: got %b want 0000", tag,
                         {branch_ready, done, redirect_valid, misaligned});
    end
    @(negedge clk);                     // N+2
    #1;
    case (kind)
      K_ERROR: begin
        checks++;
        if ({misaligned, done, redirect_valid} !== 3'b100) begin
          errors++; $display("FAIL %s error_pulse: got %b want 100", tag,
                             {misaligned, done, redirect_valid});
        end
      end
      K_DONE: begin
        checks++;
        if ({done, redirect_valid, misaligned, taken, link_value} !== {3'b100, etk, elnk}) begin
          errors++; $display("FAIL %s done: got d%b v%b m%b t%b l%h want d1 v0 m0 t%b l%h",
                             tag, done, redirect_valid, misaligned, taken, link_value, etk, elnk);
        end
      end
      default: begin
        checks++;
        if ({redirect_valid, done, redirect_target} !== {2'b10, etgt}) begin
          errors++; $display("FAIL %s redirect: got v%b d%b tgt %h want v1 d0 tgt %h",
                             tag, redirect_valid, done, redirect_target, etgt);
        end
        for (int i = 0; i < delay; i++) begin
          @(negedge clk);
          #1;
          checks++;
          if ({redirect_valid, done, redirect_target} !== {2'b10, etgt}) begin
            errors++; $display("FAIL %s redirect_hold: got v%b d%b tgt %h want v1 d0 tgt %h",
                               tag, redirect_valid, done, redirect_target, etgt);
          end
        end
        redirect_ready = 1'b1;
        #1;
        checks++;
        if ({done, taken, link_value} !== {1'b1, etk, elnk}) begin
          errors++; $display("FAIL %s handshake_done: got d%b t%b l%h want d1 t%b l%h",
                             tag, done, taken, link_value, etk, elnk);
        end
      end
    endcase
    @(negedge clk);
    redirect_ready = 1'b0;
    #1;
    checks++;
    if ({branch_ready, done, redirect_valid, misaligned} !== 4'b1000) begin
      errors++; $display("FAIL %s back_to_idle: got %b want 1000", tag,
                         {branch_ready, done, redirect_valid, misaligned});
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({branch_ready, redirect_valid, done, taken, misaligned, redirect_target, link_value}
        !== {5'b10000, 32'd0, 32'd0}) begin
      errors++; $display("FAIL %s reset_values: got r%b v%b d%b t%b m%b tgt %h l%h want r1 v0 d0 t0 m0 tgt 0 l0",
                         tag, branch_ready, redirect_valid, done, taken, misaligned,
                         redirect_target, link_value);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_beq_redirect();
    run_instr("beq", mk(CMP_OP_EQ, 0, 0, 32'h10, 32'h10, 32'h100, 32'h20, 1'b0), 3);
  endtask

  task automatic test_blt_bltu();
    run_instr("blt",  mk(CMP_OP_LT,  0, 0, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b0), 1);
    run_instr("bltu", mk(CMP_OP_LTU, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b0), 0);
    run_instr("unknown_sel", mk(3'b010, 0, 0, 32'd5, 32'd5, 32'h280, 32'h8, 1'b0), 0);
  endtask

  task automatic test_jalr();
    run_instr("jalr_mis", mk(CMP_OP_EQ, 0, 1, 32'h203, 32'd0, 32'h300, 32'd0, 1'b1), 0);
    run_instr("jalr_ok",  mk(CMP_OP_EQ, 0, 1, 32'h205, 32'd0, 32'h300, 32'hFFFF_FFFF, 1'b0), 2);
    run_instr("jal_jalr", mk(CMP_OP_EQ, 1, 1, 32'h400, 32'd0, 32'h300, 32'h8, 1'b0), 0);
  endtask

  task automatic test_jal_wrap();
    run_instr("jal_wrap", mk(CMP_OP_EQ, 1, 0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 1'b0), 0);
  endtask

  task automatic test_flush();
    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    present(mk(CMP_OP_EQ, 1, 0, 32'd0, 32'd0, 32'h500, 32'h40, 1'b0));
    flush = 1'b1;
    #1;
    checks++;
    if (branch_ready !== 1'b0) begin
      errors++; $display("FAIL flush_idle_ready: got %b want 0", branch_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    branch_valid = 1'b0;
    #1;
    checks++;
    if (branch_ready !== 1'b1) begin
      errors++; $display("FAIL flush_idle_no_accept: got %b want 1", branch_ready);
    end
    // Flush in REDIRECT together with a ready handshake.
    @(negedge clk);
    present(mk(CMP_OP_EQ, 1, 0, 32'd0, 32'd0, 32'h500, 32'h40, 1'b0));
    @(negedge clk);
    branch_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (redirect_valid !== 1'b1) begin
      errors++; $display("FAIL flush_setup_redirect: got %b want 1", redirect_valid);
    end
    flush = 1'b1;
    redirect_ready = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL flush_redirect_done: got %b want 0", done);
    end
    @(negedge clk);
    flush = 1'b0;
    redirect_ready = 1'b0;
    #1;
    checks++;
    if ({branch_ready, redirect_valid, done} !== 3'b100) begin
      errors++; $display("FAIL flush_redirect_idle: got %b want 100",
                         {branch_ready, redirect_valid, done});
    end
  endtask

  task automatic test_reset_in_eval();
    @(negedge clk);
    present(mk(CMP_OP_EQ, 1, 0, 32'd0, 32'd0, 32'h600, 32'h20, 1'b0));
    @(negedge clk);                     // EVAL
    branch_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_reset_values("reset_eval");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_reset_values("reset_eval_after");
  endtask

`ifdef BRANCH_PREDICT_EN
  task automatic test_predict();
    run_instr("pred_bne_nt", mk(CMP_OP_NE, 0, 0, 32'd7, 32'd7, 32'h40, 32'h100, 1'b1), 1);
    run_instr("pred_beq_ok", mk(CMP_OP_EQ, 0, 0, 32'd9, 32'd9, 32'h40, 32'h100, 1'b1), 0);
  endtask
`endif

  task automatic test_random();
    instr_t x;
    int     kind_sel;
    for (int n = 0; n < 60; n++) begin
      x.rs1  = $urandom();
      case ($urandom_range(0, 3))
        0:       x.rs2 = x.rs1;
        1:       x.rs2 = ~x.rs1;
        default: x.rs2 = $urandom();
      endcase
      x.pc   = $urandom() & 32'hFFFF_FFFC;
      x.imm  = 32'($urandom_range(0, 511)) - 32'd256;
      if ($urandom_range(0, 1) == 0) x.imm = x.imm & 32'hFFFF_FFFC;
      x.sel  = 3'($urandom_range(0, 7));
      kind_sel = $urandom_range(0, 5);
      x.jal  = (kind_sel == 0) || (kind_sel == 2);
      x.jalr = (kind_sel == 1) || (kind_sel == 2);
      x.pred = 1'($urandom_range(0, 1));
      run_instr("random", x, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_beq_redirect();
    test_blt_bltu();
    test_jalr();
    test_jal_wrap();
    test_flush();
    test_reset_in_eval();
`ifdef BRANCH_PREDICT_EN
    test_predict();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
